// File: rtl/led_blinker.sv
// led_blinker: free-running LED pattern generator used as a clock-domain
// liveness indicator. A CNT_WIDTH-bit counter defines one pattern period;
// the LED shows a square blink, a breathing PWM, a heartbeat or solid on,
// and period_pulse marks every counter wrap.
module led_blinker #(
   parameter int CNT_WIDTH = 27,
   parameter int PWM_BITS  = 8
) (
   input  logic       clk_128M,
   input  logic       rst_128M,
   input  logic [1:0] mode,
   output logic       led,
   output logic       period_pulse
);

   // Breathing mode takes PWM_BITS+1 top bits for the ramp and PWM_BITS low
   // bits for the PWM phase; the two fields must not overlap.
   generate
      if (PWM_BITS < 1 || CNT_WIDTH < 2*PWM_BITS+1) begin : g_bad_params
         $error("led_blinker: need PWM_BITS >= 1 and CNT_WIDTH >= 2*PWM_BITS+1");
      end
   endgenerate

   localparam logic [1:0] MODE_SQUARE = 2'd0;
   localparam logic [1:0] MODE_BREATH = 2'd1;
   localparam logic [1:0] MODE_HEART  = 2'd2;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 led_q, led_d;
   logic                 pulse_q, pulse_d;

   logic [PWM_BITS:0]    ramp;   // position within the breathing triangle
   logic [PWM_BITS-1:0]  duty;   // current breathing duty
   logic [PWM_BITS-1:0]  phase;  // position within the current PWM slot
   logic [3:0]           slot;   // heartbeat slot, 16 per period

   assign ramp  = cnt_q[CNT_WIDTH-1 -: PWM_BITS+1];
   assign duty  = ramp[PWM_BITS] ? ~ramp[PWM_BITS-1:0] : ramp[PWM_BITS-1:0];
   assign phase = cnt_q[PWM_BITS-1:0];

   // Narrow counters are left-justified so the slot still splits the period
   // into 16 equal parts where possible.
   generate
      if (CNT_WIDTH >= 4) begin : g_slot_wide
         assign slot = cnt_q[CNT_WIDTH-1 -: 4];
      end else begin : g_slot_narrow
         assign slot = {cnt_q, {(4-CNT_WIDTH){1'b0}}};
      end
   endgenerate

   // Next-state: counter always advances, pulse flags the wrap, LED pattern
   // is a pure function of the current mode and counter.
   always_comb begin
      cnt_d   = cnt_q + CNT_ONE;
      pulse_d = (cnt_q == '1);
      led_d   = 1'b1;
      case (mode)
         MODE_SQUARE: led_d = cnt_q[CNT_WIDTH-1];
         MODE_BREATH: led_d = (phase < duty);
         MODE_HEART:  led_d = (slot == 4'd0) || (slot == 4'd2);
         default:     led_d = 1'b1;
      endcase
   end

   // State registers; reset clears everything immediately.
   always_ff @(posedge clk_128M or posedge rst_128M) begin
      if (rst_128M) begin
         cnt_q   <= '0;
         led_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         led_q   <= led_d;
         pulse_q <= pulse_d;
      end
   end

   assign led          = led_q;
   assign period_pulse = pulse_q;

endmodule

// File: tb/tb_led_blinker.sv
// tb_led_blinker: directed bench for led_blinker with a 512-clock period.
// The bench tracks the counter value itself and compares LED and pulse
// activity against hand-computed window counts and edge positions.
module tb_led_blinker;

   localparam int CW = 9;
   localparam int PB = 4;
   localparam int PERIOD = 512;

   logic       clk_128M = 1'b0;
   logic       rst_128M;
   logic [1:0] mode;
   logic       led;
   logic       period_pulse;

   int n_chk = 0;
   int n_err = 0;
   int tcnt  = 0;            // counter value the DUT currently holds
   bit led_at [0:PERIOD-1];  // led produced by each counter value
   bit pul_at [0:PERIOD-1];  // pulse seen when the counter holds this value
   int gap;
   int npul;

   led_blinker #(.CNT_WIDTH(CW), .PWM_BITS(PB)) u_dut (
      .clk_128M     (clk_128M),
      .rst_128M     (rst_128M),
      .mode         (mode),
      .led          (led),
      .period_pulse (period_pulse)
   );

   always #5 clk_128M = ~clk_128M;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk_128M);
      @(negedge clk_128M);
      tcnt = (tcnt + 1) % PERIOD;
   endtask

   // Run one full period, recording led by producing counter value.
   task automatic run_period();
      for (int i = 0; i < PERIOD; i++) begin
         step();
         led_at[(tcnt + PERIOD - 1) % PERIOD] = led;
         pul_at[tcnt] = period_pulse;
      end
   endtask

   function automatic int lit(input int lo, input int hi);
      int s = 0;
      for (int i = lo; i <= hi; i++) s += int'(led_at[i]);
      return s;
   endfunction

   function automatic int pulses();
      int s = 0;
      for (int i = 0; i < PERIOD; i++) s += int'(pul_at[i]);
      return s;
   endfunction

   initial begin
      rst_128M = 1'b1;
      mode     = 2'd0;
      repeat (5) @(negedge clk_128M);
      check("rst_led", led, 0);
      check("rst_pulse", period_pulse, 0);

      // Run in solid mode, then hit reset asynchronously around cnt=100.
      rst_128M = 1'b0;
      tcnt = 0;
      mode = 2'd3;
      repeat (100) step();
      check("solid_before_rst", led, 1);
      #2 rst_128M = 1'b1;
      #1;
      check("async_rst_led", led, 0);
      check("async_rst_pulse", period_pulse, 0);
      repeat (2) @(negedge clk_128M);
      mode = 2'd0;
      rst_128M = 1'b0;
      tcnt = 0;

      // Square
      run_period();
      check("sq_lo_half", lit(0, 255), 0);
      check("sq_hi_half", lit(256, 511), 256);
      check("sq_255", led_at[255], 0);
      check("sq_256", led_at[256], 1);
      check("sq_511", led_at[511], 1);
      check("sq_pulse_cnt", pulses(), 1);
      check("sq_pulse_pos", pul_at[0], 1);
      check("sq_led_after_wrap", led, 1);
      step();
      check("sq_fall_after_wrap", led, 0);
      repeat (PERIOD - 1) step();

      // Breathing
      mode = 2'd1;
      run_period();
      check("br_win0", lit(0, 15), 0);
      check("br_win1", lit(16, 31), 1);
      check("br_win15", lit(240, 255), 15);
      check("br_win16", lit(256, 271), 15);
      check("br_win30", lit(480, 495), 1);
      check("br_win31", lit(496, 511), 0);
      check("br_total", lit(0, 511), 240);
      check("br_pulse_cnt", pulses(), 1);

      // Heartbeat
      mode = 2'd2;
      run_period();
      check("hb_flash1", lit(0, 31), 32);
      check("hb_gap", lit(32, 63), 0);
      check("hb_flash2", lit(64, 95), 32);
      check("hb_dark", lit(96, 511), 0);
      check("hb_pulse_pos", pul_at[0], 1);

      // Solid: led still shows heartbeat output of cnt=511 until next edge.
      mode = 2'd3;
      check("solid_latency", led, 0);
      run_period();
      check("solid_total", lit(0, 511), 512);
      check("solid_pulse_cnt", pulses(), 1);

      // Square to heartbeat switch at cnt=300; period spacing must hold.
      mode = 2'd0;
      gap  = 0;
      npul = 0;
      repeat (300) begin
         step();
         gap++;
         if (period_pulse) npul++;
      end
      check("sw_cnt", tcnt, 300);
      check("sw_led_before", led, 1);
      mode = 2'd2;
      step();
      gap++;
      check("sw_led_after", led, 0);
      check("sw_no_early_pulse", npul, 0);
      while (gap < 600) begin
         step();
         gap++;
         if (period_pulse) break;
      end
      check("sw_pulse_gap", gap, 512);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/led_blinker.md
Name: led_blinker

Overview:
- Free-running, parameterised LED pattern generator used as a liveness indicator for a clock domain, e.g. the 128 MHz fabric clock or the FT interface clock.
- Drives one LED pin with a selectable pattern: square blink, breathing PWM, heartbeat, or solid on.
- Also emits a one-cycle pulse once per pattern period.
- Single clock domain; no CDC inside the block.

Parameters:
- CNT_WIDTH, default 27: width of the free-running period counter. One pattern period is 2^CNT_WIDTH clocks, about 1.05 s at 128 MHz.
- PWM_BITS, default 8: PWM resolution for breathing mode. Legal only if CNT_WIDTH >= 2*PWM_BITS+1 and PWM_BITS >= 1; otherwise elaboration must fail via a generate-time error.

Ports:
- clk_128M  input  1  sole clock, rising edge.
- rst_128M  input  1  asynchronous reset, active-high.
- mode  input  2  pattern select: 0 square, 1 breathing, 2 heartbeat, 3 solid on. Sampled every clock.
- led  output  1  registered LED drive, 1 = lit.
- period_pulse  output  1  registered, high for exactly one clock when the counter wraps.

Behaviour:
- Reset (async assert; release is synchronised by the parent):
  - cnt = 0, led = 0, period_pulse = 0.
  - Reset mid-operation clears everything immediately, independent of the clock.
- Counter:
  - cnt (CNT_WIDTH bits) increments by 1 every clock.
  - Wraps from all-ones to 0 with no stall; it is never reset by a mode change.
- period_pulse: registered; next-cycle value = (cnt == all-ones). High on the clock edge where cnt becomes 0.
- led: registered, one clock latency; next-cycle value is f(mode, cnt) on current values.
- mode 0, square:
  - led_next = cnt[CNT_WIDTH-1].
  - Duty 50%: low for the first half-period, high for the second.
- mode 1, breathing:
  - t = cnt[CNT_WIDTH-1 -: PWM_BITS+1].
  - duty = t[PWM_BITS] ? ~t[PWM_BITS-1:0] : t[PWM_BITS-1:0] (triangle ramp up, then down).
  - p = cnt[PWM_BITS-1:0].
  - led_next = (p < duty), unsigned compare.
  - duty = 0 gives a fully dark slot; the maximum duty 2^PWM_BITS-1 gives one dark clock per PWM slot.
- mode 2, heartbeat:
  - s = cnt[CNT_WIDTH-1 -: 4] (16 slots per period).
  - led_next = 1 when s == 0 or s == 2, else 0.
  - Two short flashes, each 1/16 of the period, separated by one dark slot.
- mode 3, solid: led_next = 1.
- Mode changes:
  - Take effect on led one clock after the new value is sampled.
  - No glitch suppression and no phase realignment; the pattern continues from the current cnt.
- All outputs are driven from flops; no combinational path from mode to led.

Test Plan (CNT_WIDTH=9, PWM_BITS=4, so period = 512 clocks):
- Reset: hold rst_128M=1 for 5 clocks, then assert it asynchronously mid-count (cnt≈100) -> led=0, period_pulse=0 immediately; after release cnt restarts at 0.
- mode=0 from reset:
  - led=0 while cnt ∈ [0,255]; led rises one clock after cnt=256 and falls one clock after cnt wraps to 0.
  - period_pulse high exactly once per 512 clocks, on the edge where cnt becomes 0.
- mode=1:
  - Window cnt=0..15 (duty 0): led never high.
  - Window cnt=240..255 (t=15, duty 15): led high for 15 of 16 clocks.
  - Window cnt=256..271 (t=16, duty 15): again 15 of 16.
  - Window cnt=496..511 (duty 0): led never high.
  - Count of lit clocks per 16-clock window is symmetric about the period midpoint.
- mode=2: led high only for cnt ∈ [0,31] and [64,95] (+1 clock latency) -> 64 lit clocks per 512.
- mode=3: led=1 continuously, starting one clock after mode is set; period_pulse still fires every 512 clocks.
- Mode switch at cnt=300, 0→2:
  - led is 1 at the switch; one clock later led=0 (slot 9).
  - cnt continues without reset, and period_pulse keeps its 512-clock spacing.
